mdu_iter: RTL
=============

Name: mdu_iter

Overview:
Iterative multiply/divide unit implementing the RV32M operation set. It sits beside the single-cycle ALU in the EXU and takes one operation at a time through a valid/ready handshake. It computes one bit per cycle and returns the result through a second valid/ready handshake. The datapath width is parametrised (XLEN), and a flush input lets a squashed instruction be abandoned.

Parameters:
- XLEN, 32, operand/result width in bits; must be ≥ 4.
- CNTW, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  in  XLEN  rs1 (multiplicand / dividend).
- src2  in  XLEN  rs2 (multiplier / divisor).
- flush  in  1  abandon any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  operation result.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n, sampled at the clk rising edge.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, internal accumulators=0.
  - Reset mid-operation discards the operation; no result is produced.
- States:
  - IDLE: in_ready=1.
    - On in_valid: latch op, src1, src2; compute absolute values and result sign.
    - If the op is special (see below), go to DONE next cycle; otherwise go to CALC with counter=0.
  - CALC: one iteration per cycle, counter increments.
    - After the XLEN-th iteration (counter==XLEN-1 at the edge), form the sign-corrected result, register it, go to DONE.
  - DONE: out_valid=1, result stable.
    - On out_ready: return to IDLE.
    - Hold indefinitely while out_ready=0.
- Latency: the accept edge is cycle 0; normal ops raise out_valid at cycle XLEN+1; special ops raise it at cycle 1. No accept occurs in CALC or DONE.
- Multiply:
  - Radix-2 shift-add on magnitudes, producing a 2*XLEN-bit product.
  - Signedness: MUL and MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - If the result sign is negative, negate the full 2*XLEN product.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes: remainder left-shifts in one dividend bit per cycle, subtracts the divisor if no borrow, and shifts in the quotient bit.
  - Quotient sign = sign(src1) XOR sign(src2), applied for DIV only.
  - Remainder sign = sign(src1), applied for REM only.
- Special ops (single-cycle, decided in IDLE):
  - Divisor == 0: DIV/DIVU → all ones; REM/REMU → src1.
  - Signed overflow (src1 == 1 followed by XLEN-1 zeros and src2 == all ones) with DIV → src1; with REM → 0.
- Flush:
  - flush=1 in CALC or DONE → IDLE at the next edge, out_valid=0 at the next edge.
  - flush in IDLE blocks acceptance that cycle: in_valid is ignored while flush=1.
  - flush has priority over out_ready and in_valid; reset has priority over flush.
- Handshake invariants:
  - out_valid never drops without a handshake, a flush or a reset.
  - result does not change while out_valid=1.

Decomposition:
- Shared package mdu_pkg holds:
  - The op localparams (MDU_MUL … MDU_REMU, matching funct3).
  - The state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - Helper predicates is_div(op) and is_signed_src1/src2(op).
- One natural combinational sub-module, mdu_divstep: takes the partial remainder, divisor and next dividend bit; returns the next remainder and quotient bit. It keeps the CALC datapath readable.
- The multiply step stays inline.

Test Plan:
- MUL src1=0x00000007 src2=0xFFFFFFFD, out_ready=1 → result 0xFFFFFFEB; out_valid exactly 33 cycles after accept; in_ready low for cycles 1..33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9/0x00000002 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 0x12345678/0 → 0xFFFFFFFF at cycle 1.
  - REMU 0x12345678/0 → 0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and result stable; then out_ready=1 → IDLE next cycle, in_ready=1.
- Flush and reset:
  - Assert flush at CALC counter=10 → out_valid never rises, in_ready=1 next cycle; a new MUL 3×5 then returns 15.
  - Repeat with rst_n=0 for one cycle instead of flush → same recovery, result reads 0 until the next completion.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and operand-signedness predicates.
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_src1(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic is_signed_src2(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor
// when that does not borrow, and report the resulting quotient bit.
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] divisor,
    input  logic            dvd_bit,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[XLEN];
    assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign-corrected at the end; divide-by-zero and signed overflow finish at once.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    mdu_state_e      state;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] opb_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [CNTW-1:0] cnt;

    // Request decode, evaluated in IDLE
    logic            s1_neg, s2_neg, neg_in;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] special_res;

    assign s1_neg   = is_signed_src1(op) & src1[XLEN-1];
    assign s2_neg   = is_signed_src2(op) & src2[XLEN-1];
    assign abs1     = s1_neg ? -src1 : src1;
    assign abs2     = s2_neg ? -src2 : src2;
    assign neg_in   = (op == MDU_REM) ? s1_neg : (s1_neg ^ s2_neg);
    assign div_zero = (src2 == '0);
    assign ovf      = ((op == MDU_DIV) || (op == MDU_REM)) &&
                      (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    assign special  = is_div(op) && (div_zero || ovf);
    assign special_res = div_zero ? (op[1] ? src1 : '1)
                                  : (op[1] ? '0   : src1);

    // Multiply: hi:lo holds partial product : remaining multiplier bits
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi_nx = mul_sum[XLEN:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

    // Divide: hi holds the partial remainder, lo shifts dividend out / quotient in
    logic [XLEN-1:0] div_rem_nx, div_lo_nx;
    logic            q_bit;

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem      (hi_q),
        .divisor  (opb_q),
        .dvd_bit  (lo_q[XLEN-1]),
        .rem_next (div_rem_nx),
        .q_bit    (q_bit)
    );

    assign div_lo_nx = {lo_q[XLEN-2:0], q_bit};

    logic [XLEN-1:0]   hi_nx, lo_nx, div_sel, div_res, mul_res, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign hi_nx     = is_div(op_q) ? div_rem_nx : mul_hi_nx;
    assign lo_nx     = is_div(op_q) ? div_lo_nx  : mul_lo_nx;
    assign prod      = {hi_nx, lo_nx};
    assign prod_s    = neg_q ? -prod : prod;
    assign mul_res   = (op_q == MDU_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    assign div_sel   = op_q[1] ? hi_nx : lo_nx;
    assign div_res   = neg_q ? -div_sel : div_sel;
    assign final_res = is_div(op_q) ? div_res : mul_res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            op_q      <= MDU_MUL;
            neg_q     <= 1'b0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_q     <= op;
                        neg_q    <= neg_in;
                        cnt      <= '0;
                        hi_q     <= '0;
                        lo_q     <= is_div(op) ? abs1 : abs2;
                        opb_q    <= is_div(op) ? abs2 : abs1;
                        in_ready <= 1'b0;
                        if (special) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        hi_q <= hi_nx;
                        lo_q <= lo_nx;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNTW'(XLEN-1)) begin
                            result    <= final_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
